vga_fb_scaler_reader: RTL and testbench

- Parametrised, pipelined frame-buffer read-out engine between the VGA timing generator and a dual-buffered RGB frame buffer.
- Maps screen coordinates to source pixels with power-of-two up-scaling, letterboxing and a registered read pipeline of configurable latency.
- Converts three pixel formats plus a test pattern to 4-bit VGA channels.
- Owns front/back buffer selection with a swap that takes effect only during vertical blanking.

---
 rtl/vga_fb_scaler_reader.sv | 208 ++++++++++++++++++++
 tb/tb_vga_fb_scaler_reader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scaler_reader.sv
// Frame-buffer read-out engine: maps screen coordinates onto an up-scaled, letterboxed
// source frame, issues registered reads into the front buffer, converts the returned
// pixel to 4-bit VGA channels and delays the sync/enable strobes to stay aligned with RGB.
// Row base addresses are tracked incrementally, so y_pixel is expected to follow a raster
// order (same line, next line, or back to line 0).
module vga_fb_scaler_reader #(
   parameter int unsigned SRC_W       = 320,
   parameter int unsigned SRC_H       = 240,
   parameter int unsigned SCALE_SHIFT = 1,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned ADDR_W      = 18,
   parameter logic [11:0] BORDER_RGB  = 12'h000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pix_en,
   input  logic              DE,
   input  logic [9:0]        x_pixel,
   input  logic [9:0]        y_pixel,
   input  logic              h_sync,
   input  logic              v_sync,
   input  logic [1:0]        fmt_sel,
   input  logic              swap_req,
   output logic              den,
   output logic [ADDR_W-1:0] rAddr,
   input  logic [15:0]       rData,
   output logic              front_idx,
   output logic              swap_ack,
   output logic              de_out,
   output logic              hs_out,
   output logic              vs_out,
   output logic [3:0]        r_port,
   output logic [3:0]        g_port,
   output logic [3:0]        b_port
);

   localparam int unsigned       Stages    = RD_LAT + 1;
   localparam logic [10:0]       SrcWC     = 11'(SRC_W);
   localparam logic [10:0]       SrcHC     = 11'(SRC_H);
   localparam logic [9:0]        SwapLine  = 10'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] RowStride = ADDR_W'(SRC_W);
   localparam logic [ADDR_W-1:0] FrameSize = ADDR_W'(SRC_W * SRC_H);

   // One delay-line word per pixel tick; idle value matches the reset state of the outputs.
   typedef struct packed {
      logic       fv;
      logic       win;
      logic       de;
      logic       hs;
      logic       vs;
      logic [2:0] bar;
   } dly_t;

   localparam dly_t DlyIdle = '{fv: 1'b0, win: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1, bar: 3'b000};

   logic [9:0]        sx, sy;
   logic              frame_start, fv_eff, in_win, swap_point;
   logic [1:0]        fmt_eff;
   logic [ADDR_W-1:0] row_base_cur, addr_next;

   logic              den_q, den_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              fv_q, fv_d;
   logic [1:0]        fmt_q, fmt_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [9:0]        sy_track_q, sy_track_d;
   logic              front_q, front_d;
   logic              pending_q, pending_d;
   logic              ack_q, ack_d;

   logic [Stages*8-1:0] dly_q;
   dly_t                dly_in, dly_out;

   logic        de_out_q, hs_out_q, vs_out_q;
   logic [11:0] rgb_q, rgb_d;

   assign sx          = x_pixel >> SCALE_SHIFT;
   assign sy          = y_pixel >> SCALE_SHIFT;
   assign frame_start = DE && (x_pixel == 10'd0) && (y_pixel == 10'd0);
   // The frame-start pixel itself already belongs to the new frame.
   assign fv_eff      = fv_q || frame_start;
   assign fmt_eff     = frame_start ? fmt_sel : fmt_q;
   assign in_win      = DE && fv_eff && ({1'b0, sx} < SrcWC) && ({1'b0, sy} < SrcHC);
   assign swap_point  = (y_pixel == SwapLine) && (x_pixel == 10'd0);

   // Row base follows sy by restarting at 0 or stepping one source row at a time.
   always_comb begin
      if (sy == 10'd0) begin
         row_base_cur = '0;
      end else if (sy == sy_track_q + 10'd1) begin
         row_base_cur = row_base_q + RowStride;
      end else begin
         row_base_cur = row_base_q;
      end
      addr_next = (front_q ? FrameSize : '0) + row_base_cur + ADDR_W'(sx);
   end

   // Next state of the address front end, frame tracking and buffer swap.
   always_comb begin
      den_d      = den_q;
      addr_d     = addr_q;
      fv_d       = fv_q;
      fmt_d      = fmt_q;
      row_base_d = row_base_q;
      sy_track_d = sy_track_q;
      front_d    = front_q;
      pending_d  = pending_q || swap_req;
      ack_d      = 1'b0;
      if (pix_en) begin
         den_d      = in_win && (fmt_eff != 2'd3);
         if (den_d) begin
            addr_d = addr_next;
         end
         fv_d       = fv_eff;
         fmt_d      = fmt_eff;
         row_base_d = row_base_cur;
         sy_track_d = sy;
         if (swap_point && (pending_q || swap_req)) begin
            front_d   = ~front_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
         end
      end
   end

   // Front-end state registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         den_q      <= 1'b0;
         addr_q     <= '0;
         fv_q       <= 1'b0;
         fmt_q      <= 2'd0;
         row_base_q <= '0;
         sy_track_q <= 10'd0;
         front_q    <= 1'b0;
         pending_q  <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         den_q      <= den_d;
         addr_q     <= addr_d;
         fv_q       <= fv_d;
         fmt_q      <= fmt_d;
         row_base_q <= row_base_d;
         sy_track_q <= sy_track_d;
         front_q    <= front_d;
         pending_q  <= pending_d;
         ack_q      <= ack_d;
      end
   end

   assign dly_in  = '{fv: fv_eff, win: in_win, de: DE, hs: h_sync, vs: v_sync,
                      bar: x_pixel[9:7]};
   assign dly_out = dly_q[Stages*8-1 -: 8];

   // Strobe delay line spanning the read latency plus the address register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dly_q <= {Stages{DlyIdle}};
      end else if (pix_en) begin
         dly_q <= {dly_q[(Stages-1)*8-1:0], dly_in};
      end
   end

   // Pixel conversion for the word that leaves the delay line.
   always_comb begin
      rgb_d = 12'h000;
      if (dly_out.de && dly_out.fv) begin
         if (!dly_out.win) begin
            rgb_d = BORDER_RGB;
         end else begin
            case (fmt_q)
               2'd0:    rgb_d = {rData[15:12], rData[10:7], rData[4:1]};
               2'd1:    rgb_d = rData[11:0];
               2'd2:    rgb_d = {rData[7:4], rData[7:4], rData[7:4]};
               default: rgb_d = {{4{dly_out.bar[2]}}, {4{dly_out.bar[1]}}, {4{dly_out.bar[0]}}};
            endcase
         end
      end
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         de_out_q <= 1'b0;
         hs_out_q <= 1'b1;
         vs_out_q <= 1'b1;
         rgb_q    <= 12'h000;
      end else if (pix_en) begin
         de_out_q <= dly_out.de;
         hs_out_q <= dly_out.hs;
         vs_out_q <= dly_out.vs;
         rgb_q    <= rgb_d;
      end
   end

   assign den       = den_q;
   assign rAddr     = addr_q;
   assign front_idx = front_q;
   assign swap_ack  = ack_q;
   assign de_out    = de_out_q;
   assign hs_out    = hs_out_q;
   assign vs_out    = vs_out_q;
   assign r_port    = rgb_q[11:8];
   assign g_port    = rgb_q[7:4];
   assign b_port    = rgb_q[3:0];

endmodule

// File: tb/tb_vga_fb_scaler_reader.sv
// Scoreboard bench for vga_fb_scaler_reader on a shrunken raster: x steps by 24 so the bar
// index covers all eight values, and a small source window leaves letterbox on both axes.
module tb_vga_fb_scaler_reader;

   localparam int unsigned SRC_W       = 200;
   localparam int unsigned SRC_H       = 10;
   localparam int unsigned SCALE_SHIFT = 1;
   localparam int unsigned V_ACTIVE    = 24;
   localparam int unsigned RD_LAT      = 2;
   localparam int unsigned ADDR_W      = 12;
   localparam logic [11:0] BORDER      = 12'h5A3;

   localparam int H_TOT = 48;
   localparam int H_ACT = 40;
   localparam int V_TOT = 28;
   localparam int XSTEP = 24;

   typedef struct packed {
      logic        de;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } out_t;

   typedef struct {
      logic              den;
      logic [ADDR_W-1:0] addr;
      logic              front;
      logic              ack;
      out_t              o;
   } exp_t;

   localparam out_t IDLE = '{de: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 12'h000};

   logic              clk, reset_n, pix_en, DE, h_sync, v_sync, swap_req;
   logic [9:0]        x_pixel, y_pixel;
   logic [1:0]        fmt_sel;
   logic              den, front_idx, swap_ack, de_out, hs_out, vs_out;
   logic [ADDR_W-1:0] rAddr;
   logic [15:0]       rData;
   logic [3:0]        r_port, g_port, b_port;

   vga_fb_scaler_reader #(
      .SRC_W      (SRC_W),
      .SRC_H      (SRC_H),
      .SCALE_SHIFT(SCALE_SHIFT),
      .V_ACTIVE   (V_ACTIVE),
      .RD_LAT     (RD_LAT),
      .ADDR_W     (ADDR_W),
      .BORDER_RGB (BORDER)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .pix_en   (pix_en),
      .DE       (DE),
      .x_pixel  (x_pixel),
      .y_pixel  (y_pixel),
      .h_sync   (h_sync),
      .v_sync   (v_sync),
      .fmt_sel  (fmt_sel),
      .swap_req (swap_req),
      .den      (den),
      .rAddr    (rAddr),
      .rData    (rData),
      .front_idx(front_idx),
      .swap_ack (swap_ack),
      .de_out   (de_out),
      .hs_out   (hs_out),
      .vs_out   (vs_out),
      .r_port   (r_port),
      .g_port   (g_port),
      .b_port   (b_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame-buffer model: random contents, RD_LAT pixel ticks of read latency.
   logic [15:0] mem [1 << ADDR_W];
   logic [15:0] rd_pipe [RD_LAT];

   always @(posedge clk) begin
      if (pix_en) begin
         rd_pipe[0] <= mem[rAddr];
         for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
      end
   end
   assign rData = rd_pipe[RD_LAT-1];

   // Reference model state.
   logic              m_fv, m_front, m_pend, m_den;
   logic [1:0]        m_fmt;
   logic [ADDR_W-1:0] m_addr;
   out_t              pipe_q[$];
   out_t              cur_out;
   exp_t              sb_q[$];

   int n_vec  = 0;
   int n_miss = 0;

   int         hcnt, vcnt, frame, cyc;
   logic [1:0] fmt_v;

   function automatic logic [11:0] conv(input logic [1:0] f, input logic [15:0] d,
                                        input logic [2:0] bar);
      case (f)
         2'd0:    return {d[15:12], d[10:7], d[4:1]};
         2'd1:    return d[11:0];
         2'd2:    return {d[7:4], d[7:4], d[7:4]};
         default: return {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      endcase
   endfunction

   // Expected response to one clock edge, pushed onto the scoreboard.
   task automatic model_step(input logic rst_n_v, input logic pe_v, input logic de_v,
                             input logic hs_v, input logic vs_v, input logic [9:0] xv,
                             input logic [9:0] yv, input logic [1:0] f_in, input logic sreq_v);
      exp_t              e;
      out_t              o;
      int                sx, sy;
      logic              start, fv_eff, win, ack;
      logic [1:0]        fe;
      logic [ADDR_W-1:0] a;
      ack = 1'b0;
      if (!rst_n_v) begin
         m_fv = 1'b0; m_fmt = 2'd0; m_front = 1'b0; m_pend = 1'b0; m_den = 1'b0; m_addr = '0;
         pipe_q.delete();
         for (int k = 0; k < RD_LAT + 1; k++) pipe_q.push_back(IDLE);
         cur_out = IDLE;
      end else if (pe_v) begin
         start  = de_v && (xv == 10'd0) && (yv == 10'd0);
         fv_eff = m_fv || start;
         fe     = start ? f_in : m_fmt;
         sx     = int'(xv) / (1 << SCALE_SHIFT);
         sy     = int'(yv) / (1 << SCALE_SHIFT);
         win    = de_v && fv_eff && (sx < SRC_W) && (sy < SRC_H);
         a      = ADDR_W'(int'(m_front) * SRC_W * SRC_H + sy * SRC_W + sx);
         m_den  = win && (fe != 2'd3);
         if (m_den) m_addr = a;
         o.de = de_v; o.hs = hs_v; o.vs = vs_v;
         if (!de_v || !fv_eff) o.rgb = 12'h000;
         else if (!win) o.rgb = BORDER;
         else o.rgb = conv(fe, mem[a], xv[9:7]);
         if (yv == V_ACTIVE && xv == 10'd0 && (m_pend || sreq_v)) begin
            m_front = !m_front;
            m_pend  = 1'b0;
            ack     = 1'b1;
         end else begin
            m_pend = m_pend || sreq_v;
         end
         m_fv  = fv_eff;
         m_fmt = fe;
         pipe_q.push_back(o);
         cur_out = pipe_q.pop_front();
      end else begin
         m_pend = m_pend || sreq_v;
      end
      e.den = m_den; e.addr = m_addr; e.front = m_front; e.ack = ack; e.o = cur_out;
      sb_q.push_back(e);
   endtask

   // Drives one clock of raster input, records its expectation, then advances the raster.
   task automatic drive_clk(input logic rst_n_v, input logic pe_v, input logic sreq_v);
      logic       de_v, hs_v, vs_v;
      logic [9:0] xv, yv;
      de_v = (hcnt < H_ACT) && (vcnt < V_ACTIVE);
      xv   = 10'((hcnt * XSTEP) % 1024);
      yv   = 10'(vcnt);
      hs_v = !(hcnt >= 42 && hcnt < 46);
      vs_v = !(vcnt >= 25 && vcnt < 27);
      reset_n = rst_n_v; pix_en = pe_v; DE = de_v; x_pixel = xv; y_pixel = yv;
      h_sync = hs_v; v_sync = vs_v; fmt_sel = fmt_v; swap_req = sreq_v;
      model_step(rst_n_v, pe_v, de_v, hs_v, vs_v, xv, yv, fmt_v, sreq_v);
      @(negedge clk);
      if (pe_v) begin
         hcnt++;
         if (hcnt == H_TOT) begin
            hcnt = 0;
            vcnt++;
            if (vcnt == V_TOT) begin
               vcnt = 0;
               frame++;
            end
         end
         if (hcnt == 0 && vcnt == 0) fmt_v = 2'(frame % 4);
         if (hcnt == 0 && vcnt == 12) fmt_v = 2'($urandom_range(0, 3));
      end
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp_v);
      end
   endtask

   // Monitor: one scoreboard entry per clock edge, sampled just after the edge.
   exp_t mon_e;
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         chk("den",       32'(den),       32'(mon_e.den));
         chk("rAddr",     32'(rAddr),     32'(mon_e.addr));
         chk("front_idx", 32'(front_idx), 32'(mon_e.front));
         chk("swap_ack",  32'(swap_ack),  32'(mon_e.ack));
         chk("de_out",    32'(de_out),    32'(mon_e.o.de));
         chk("hs_out",    32'(hs_out),    32'(mon_e.o.hs));
         chk("vs_out",    32'(vs_out),    32'(mon_e.o.vs));
         chk("rgb",       32'({r_port, g_port, b_port}), 32'(mon_e.o.rgb));
      end
   end

   initial begin
      logic pe, sreq, rst_n_v, rst_done;
      for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 16'($urandom);
      hcnt = 0; vcnt = V_TOT - 2; frame = 0; cyc = 0; fmt_v = 2'd0; rst_done = 1'b0;
      repeat (3) drive_clk(1'b0, 1'b1, 1'b0);
      while (frame < 10) begin
         case (frame % 3)
            0:       pe = 1'b1;
            1:       pe = 1'($urandom_range(0, 1));
            default: pe = (cyc % 4 == 0);
         endcase
         sreq = 1'b0;
         if (frame != 3 && $urandom_range(0, 499) == 0) sreq = 1'b1;
         // Two requests in one frame must merge into a single toggle.
         if (frame == 2 && pe && hcnt == 3 && (vcnt == 5 || vcnt == 15)) sreq = 1'b1;
         // Request landing exactly on the swap point.
         if (frame == 3 && pe && hcnt == 0 && vcnt == V_ACTIVE) sreq = 1'b1;
         rst_n_v = 1'b1;
         if (frame == 6 && vcnt == 10 && hcnt == 5 && !rst_done) begin
            rst_n_v  = 1'b0;
            rst_done = 1'b1;
         end
         drive_clk(rst_n_v, pe, sreq);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if (sb_q.size() != 0) begin
         n_miss++;
         $display("FAIL drain: %0d entries left unchecked, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
